// File: rtl/hex_scan_controller.sv
// hex_scan_controller: time-multiplexes one external 4-bit to 7-segment decoder
// across NUM_DIGITS displays. Each slot presents a nibble (SETUP), captures the
// active-low decoder result into a per-digit register (CAPTURE), then idles for
// the rest of the slot (WAIT). New values arrive through a double-buffered
// handshake: a word is parked in the shadow buffer and is only moved to the
// active buffer at a frame start, so a frame never mixes old and new digits.
// Optional feature macro: HEX_LEADING_ZERO_BLANK_EN (blank leading zeros).
module hex_scan_controller #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 4,
    parameter int DIV_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic [3:0]                nibble_out,
    input  logic [6:0]                seg_in,
    output logic [7*NUM_DIGITS-1:0]   hex_out,
    output logic [2:0]                digit_idx,
    output logic                      frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
    // Last WAIT count value; irrelevant when the slot has no WAIT phase.
    localparam logic [DIV_W-1:0] WAIT_LAST  = DIV_W'(SCAN_DIV - 2);
    localparam logic             SHORT_SLOT = (SCAN_DIV == 1);

    state_t                    state_r;
    logic [DIV_W-1:0]          div_cnt_r;
    logic [4*NUM_DIGITS-1:0]   shadow_r;
    logic [4*NUM_DIGITS-1:0]   active_r;
    logic                      pending_r;

    logic                      slot_end_s;
    logic                      frame_start_s;
    logic [2:0]                next_idx_s;
    logic                      accept_s;
    logic                      swap_s;
    logic                      pending_next_s;
    logic [4*NUM_DIGITS-1:0]   active_next_s;
    logic [3:0]                setup_nibble_s;
    logic [6:0]                capture_seg_s;

    // Slot sequencing and buffer-swap decisions for the current cycle.
    always_comb begin
        slot_end_s = 1'b0;
        case (state_r)
            ST_CAPTURE: slot_end_s = SHORT_SLOT;
            ST_WAIT:    slot_end_s = (div_cnt_r == WAIT_LAST);
            default:    slot_end_s = 1'b0;
        endcase

        // A frame starts when leaving IDLE or when wrapping past the last digit.
        frame_start_s = ((state_r == ST_IDLE) && enable) ||
                        (slot_end_s && enable && (digit_idx == LAST_IDX));

        if ((state_r == ST_IDLE) || (digit_idx == LAST_IDX)) begin
            next_idx_s = 3'd0;
        end else begin
            next_idx_s = digit_idx + 3'd1;
        end

        accept_s = load_valid && load_ready;
        // Only a word that was already pending is promoted; a word accepted in
        // the frame-start cycle itself waits for the following frame.
        swap_s   = frame_start_s && pending_r;

        if (accept_s) begin
            pending_next_s = 1'b1;
        end else if (swap_s) begin
            pending_next_s = 1'b0;
        end else begin
            pending_next_s = pending_r;
        end

        if (swap_s) begin
            active_next_s = shadow_r;
        end else begin
            active_next_s = active_r;
        end

        // The nibble for the next SETUP must come from the post-swap buffer.
        setup_nibble_s = active_next_s[4*next_idx_s +: 4];
    end

`ifdef HEX_LEADING_ZERO_BLANK_EN
    logic upper_zero_s;

    // Blank a digit when it and every more significant digit are zero.
    always_comb begin
        upper_zero_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((3'(i) >= digit_idx) && (active_r[4*i +: 4] != 4'd0)) begin
                upper_zero_s = 1'b0;
            end else begin
                upper_zero_s = upper_zero_s;
            end
        end
        if (upper_zero_s && (digit_idx != 3'd0)) begin
            capture_seg_s = 7'h7F;
        end else begin
            capture_seg_s = seg_in;
        end
    end
`else
    // Without blanking the decoder output is captured unchanged.
    always_comb begin
        capture_seg_s = seg_in;
    end
`endif

    // Scan FSM, buffer handshake and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= '0;
            shadow_r   <= '0;
            active_r   <= '0;
            pending_r  <= 1'b0;
            load_ready <= 1'b1;
            nibble_out <= 4'd0;
            hex_out    <= '1;
            digit_idx  <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            if (accept_s) begin
                shadow_r <= value_in;
            end
            pending_r  <= pending_next_s;
            load_ready <= ~pending_next_s;
            active_r   <= active_next_s;
            frame_done <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (enable) begin
                        digit_idx  <= 3'd0;
                        nibble_out <= setup_nibble_s;
                        state_r    <= ST_SETUP;
                    end else begin
                        nibble_out <= 4'd0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_CAPTURE;
                end
                ST_CAPTURE, ST_WAIT: begin
                    if (state_r == ST_CAPTURE) begin
                        hex_out[7*digit_idx +: 7] <= capture_seg_s;
                        frame_done <= (digit_idx == LAST_IDX);
                    end
                    if (slot_end_s) begin
                        if (enable) begin
                            digit_idx  <= next_idx_s;
                            nibble_out <= setup_nibble_s;
                            state_r    <= ST_SETUP;
                        end else begin
                            nibble_out <= 4'd0;
                            state_r    <= ST_IDLE;
                        end
                    end else if (state_r == ST_CAPTURE) begin
                        div_cnt_r <= '0;
                        state_r   <= ST_WAIT;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                        state_r   <= ST_WAIT;
                    end
                end
                default: begin
                    nibble_out <= 4'd0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_scan_controller.sv
// Scoreboard bench for hex_scan_controller (NUM_DIGITS=6, SCAN_DIV=4).
// Expected frames are queued when stimulus is issued; a monitor compares the
// whole hex_out word every time frame_done pulses.
module tb_hex_scan_controller;

    localparam int ND = 6;
    localparam logic [41:0] BLANK = {42{1'b1}};

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [23:0]   value_in;
    logic          load_valid;
    logic          load_ready;
    logic [3:0]    nibble_out;
    logic [6:0]    seg_in;
    logic [41:0]   hex_out;
    logic [2:0]    digit_idx;
    logic          frame_done;

    int            checks;
    int            errors;
    int            cyc;
    int            last_frame_cyc;
    int            first_frame_cyc;
    logic [41:0]   exp_q[$];
    logic [41:0]   mon_exp;
    logic [41:0]   lz_exp;

    hex_scan_controller #(.NUM_DIGITS(ND), .SCAN_DIV(4), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .value_in   (value_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .nibble_out (nibble_out),
        .seg_in     (seg_in),
        .hex_out    (hex_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    // Active-low segment table, bit0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [41:0] frame_of(input logic [23:0] v);
        logic [41:0] f;
        f = '0;
        for (int k = 0; k < ND; k++) f[7*k +: 7] = seg7(v[4*k +: 4]);
        return f;
    endfunction

    assign seg_in = seg7(nibble_out);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every completed frame is checked against the queue.
    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected: got hex_out=%h, required no frame", hex_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (hex_out !== mon_exp) begin
                    errors++;
                    $display("FAIL frame_content: got hex_out=%h, required %h", hex_out, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 200);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: got no frame_done in %0d cycles, required one", name, n);
        end
        last_frame_cyc = cyc;
    endtask

    task automatic load_word(input logic [23:0] v);
        value_in   = v;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 1'b0; enable = 1'b0; load_valid = 1'b0; value_in = 24'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hex", hex_out, BLANK);
        check("rst_ready", load_ready, 1'b1);
        check("rst_idx", digit_idx, 3'd0);
        check("rst_nibble", nibble_out, 4'd0);
        check("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_nibble", nibble_out, 4'd0);
        check("idle_hex", hex_out, BLANK);

        // Basic frame and frame period
        exp_q.push_back(frame_of(24'h012345));
        exp_q.push_back(frame_of(24'h012345));
        check("ready_before_load", load_ready, 1'b1);
        load_word(24'h012345);
        check("ready_after_load", load_ready, 1'b0);
        enable = 1'b1;
        wait_frame("frame1");
        check("slot0_is_5", hex_out[6:0], 7'h12);
        check("slot5_is_0", hex_out[41:35], 7'h40);
        first_frame_cyc = last_frame_cyc;
        wait_frame("frame2");
        check("frame_period", last_frame_cyc - first_frame_cyc, 30);

        // Load during frame: second word held pending, third refused
        exp_q.push_back(frame_of(24'h111111));
        load_word(24'h111111);
        check("ready_drop_111", load_ready, 1'b0);
        repeat (12) @(negedge clk);
        check("ready_midframe", load_ready, 1'b1);
        exp_q.push_back(frame_of(24'h222222));
        load_word(24'h222222);
        check("ready_drop_222", load_ready, 1'b0);
        value_in = 24'h333333;
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("third_refused", load_ready, 1'b0);
        end
        load_valid = 1'b0;
        wait_frame("frame3");
        check("ready_pending_to_wrap", load_ready, 1'b0);
        wait_frame("frame4");
        check("ready_after_wrap", load_ready, 1'b1);

        // Accept in the same cycle as the wrap (wrap is 3 clocks after frame_done)
        exp_q.push_back(frame_of(24'h222222));
        exp_q.push_back(frame_of(24'h333333));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        load_word(24'h333333);
        check("ready_simul", load_ready, 1'b0);
        wait_frame("frame5");
        check("ready_still_pending", load_ready, 1'b0);
        wait_frame("frame6");

        // Enable drop during WAIT of digit 2
        load_word(24'h987654);
        repeat (15) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        check("drop_hex", hex_out, {7'h30, 7'h30, 7'h30, 7'h02, 7'h12, 7'h19});
        check("drop_idx", digit_idx, 3'd2);
        check("drop_nibble", nibble_out, 4'd0);
        repeat (40) @(negedge clk);
        check("drop_hold", hex_out, {7'h30, 7'h30, 7'h30, 7'h02, 7'h12, 7'h19});
        exp_q.push_back(frame_of(24'h987654));
        enable = 1'b1;
        @(negedge clk);
        check("resume_idx", digit_idx, 3'd0);
        check("resume_nibble", nibble_out, 4'h4);
        wait_frame("frame_resume");

        // Reset asserted mid-WAIT
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("midrst_hex", hex_out, BLANK);
        check("midrst_ready", load_ready, 1'b1);
        check("midrst_idx", digit_idx, 3'd0);
        check("midrst_done", frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("postrst_nibble", nibble_out, 4'd0);
        check("postrst_idx", digit_idx, 3'd0);
        check("postrst_hex", hex_out, BLANK);

        // Leading zeros
`ifdef HEX_LEADING_ZERO_BLANK_EN
        lz_exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40};
`else
        lz_exp = {7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h40};
`endif
        exp_q.push_back(lz_exp);
        load_word(24'h000070);
        enable = 1'b1;
        wait_frame("frame_lz");
        check("lz_slot1", hex_out[13:7], 7'h78);
        check("lz_slot0", hex_out[6:0], 7'h40);
        enable = 1'b0;
        repeat (10) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, required finish");
        $fatal(1);
    end

endmodule
